// File: rtl/lfsr_rr_ctrl.sv
// lfsr_rr_ctrl: one Fibonacci LFSR shared by two requesters.
// A round-robin arbiter picks a requester. The LFSR then shifts STEPS times.
// The resulting word is returned on a valid/ready channel, tagged with the winner ID.
// Seed loads are accepted only while idle.
// Optional build macro: LFSR_CTRL_FREERUN_EN. When defined, the LFSR also shifts
// in every IDLE cycle that has no seed load.
module lfsr_rr_ctrl #(
  parameter int                LENGTH = 8,
  parameter logic [LENGTH-1:0] TAPS   = 8'hB8,
  parameter logic [LENGTH-1:0] SEED   = 8'h01,
  parameter int                STEPS  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              seed_we_i,
  input  logic [LENGTH-1:0] seed_in_i,
  input  logic [1:0]        req_i,
  output logic [1:0]        gnt_o,
  output logic              rnd_valid_o,
  input  logic              rnd_ready_i,
  output logic [LENGTH-1:0] rnd_data_o,
  output logic              rnd_id_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_STEP    = 2'd1,
    S_PRESENT = 2'd2
  } state_e;

  state_e            fsm_q, fsm_d;
  logic [LENGTH-1:0] lfsr_q, lfsr_d;
  logic [LENGTH-1:0] data_q, data_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              ptr_q, ptr_d;     // requester favoured when both request
  logic [1:0]        gnt_q, gnt_d;
  logic              id_q, id_d;
  logic              valid_q, valid_d;
  logic [LENGTH-1:0] lfsr_next;
  logic              win;

  // One Fibonacci shift. A non-zero state never maps to zero.
  assign lfsr_next = {lfsr_q[LENGTH-2:0], ^(lfsr_q & TAPS)};

  // State register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm_q   <= S_IDLE;
      lfsr_q  <= SEED;
      data_q  <= '0;
      cnt_q   <= '0;
      ptr_q   <= 1'b0;
      gnt_q   <= '0;
      id_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      lfsr_q  <= lfsr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      valid_q <= valid_d;
    end
  end

  // Next-state logic: arbitration, stepping and the output handshake.
  always_comb begin
    fsm_d   = fsm_q;
    lfsr_d  = lfsr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;            // grant is a one-cycle pulse
    id_d    = id_q;
    valid_d = valid_q;
    win     = 1'b0;
    case (fsm_q)
      S_IDLE: begin
        if (seed_we_i) begin
          // A seed load wins over requests. A zero seed would lock up the LFSR.
          lfsr_d = (seed_in_i == '0) ? SEED : seed_in_i;
        end else begin
`ifdef LFSR_CTRL_FREERUN_EN
          lfsr_d = lfsr_next;
`else
          lfsr_d = lfsr_q;
`endif
          if (|req_i) begin
            win   = (req_i == 2'b11) ? ptr_q : req_i[1];
            gnt_d = win ? 2'b10 : 2'b01;
            id_d  = win;
            cnt_d = 8'(STEPS - 1);
            fsm_d = S_STEP;
          end
        end
      end
      S_STEP: begin
        lfsr_d = lfsr_next;
        cnt_d  = cnt_q - 8'd1;
        if (cnt_q == 8'd0) begin
          cnt_d   = 8'd0;
          data_d  = lfsr_next;
          valid_d = 1'b1;
          fsm_d   = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (rnd_ready_i) begin
          valid_d = 1'b0;
          ptr_d   = ~id_q;     // the next tie goes to the other requester
          fsm_d   = S_IDLE;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  assign gnt_o       = gnt_q;
  assign rnd_valid_o = valid_q;
  assign rnd_data_o  = data_q;
  assign rnd_id_o    = id_q;
  assign busy_o      = (fsm_q != S_IDLE);

endmodule

// File: tb/tb_lfsr_rr_ctrl.sv
// Directed bench for lfsr_rr_ctrl. One instance uses STEPS=1 and one uses STEPS=8.
module tb_lfsr_rr_ctrl;
  logic       clk = 1'b0;
  logic       rst, seed_we, rdy;
  logic [7:0] seed_in;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       vld, id, busy;
  logic [7:0] data;

  logic       rst8, seed_we8, rdy8;
  logic [7:0] seed_in8;
  logic [1:0] req8;
  logic [1:0] gnt8;
  logic       vld8, id8, busy8;
  logic [7:0] data8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lfsr_rr_ctrl #(.LENGTH(8), .TAPS(8'hB8), .SEED(8'h01), .STEPS(1)) dut (
    .clk_i(clk), .rst_i(rst), .seed_we_i(seed_we), .seed_in_i(seed_in),
    .req_i(req), .gnt_o(gnt), .rnd_valid_o(vld), .rnd_ready_i(rdy),
    .rnd_data_o(data), .rnd_id_o(id), .busy_o(busy));

  lfsr_rr_ctrl #(.LENGTH(8), .TAPS(8'hB8), .SEED(8'h01), .STEPS(8)) dut8 (
    .clk_i(clk), .rst_i(rst8), .seed_we_i(seed_we8), .seed_in_i(seed_in8),
    .req_i(req8), .gnt_o(gnt8), .rnd_valid_o(vld8), .rnd_ready_i(rdy8),
    .rnd_data_o(data8), .rnd_id_o(id8), .busy_o(busy8));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle, so sampling and driving happen away from the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  // Wait for a grant and check it, then wait for the word and check it.
  // rdy is held high, so the next edge completes the handshake.
  task automatic get_word(input string tag, input logic [7:0] exp_d,
                          input logic exp_id, input logic [1:0] exp_g);
    int n;
    n = 0;
    do begin tick; n++; end while (gnt == 2'b00 && n < 12);
    chk({tag, "_gnt"}, 32'(gnt), 32'(exp_g));
    n = 0;
    while (!vld && n < 20) begin tick; n++; end
    chk({tag, "_vld"}, 32'(vld), 32'd1);
    chk({tag, "_data"}, 32'(data), 32'(exp_d));
    chk({tag, "_id"}, 32'(id), 32'(exp_id));
  endtask

  initial begin
    int n;
    rst = 1'b1; seed_we = 1'b0; seed_in = 8'h00; req = 2'b00; rdy = 1'b0;
    rst8 = 1'b1; seed_we8 = 1'b0; seed_in8 = 8'h00; req8 = 2'b00; rdy8 = 1'b0;
    do_reset;
    rst = 1'b1;
    tick;
    // Outputs while reset is asserted.
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_vld", 32'(vld), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_id", 32'(id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Test 1: single requester, latency, then the sequence 02,04,08,11.
    req = 2'b01; rdy = 1'b1;
    tick;
    chk("t1_gnt_lat", 32'(gnt), 32'h1);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_vld_early", 32'(vld), 32'd0);
    tick;
    chk("t1_vld_lat", 32'(vld), 32'd1);
    chk("t1_data0", 32'(data), 32'h02);
    chk("t1_id0", 32'(id), 32'd0);
    chk("t1_gnt_pulse", 32'(gnt), 32'd0);
    get_word("t1_w1", 8'h04, 1'b0, 2'b01);
    get_word("t1_w2", 8'h08, 1'b0, 2'b01);
    get_word("t1_w3", 8'h11, 1'b0, 2'b01);
    req = 2'b00;
    tick;

    // Test 2: both requesting, so grants alternate.
    do_reset;
    req = 2'b11; rdy = 1'b1;
    get_word("t2_a", 8'h02, 1'b0, 2'b01);
    get_word("t2_b", 8'h04, 1'b1, 2'b10);
    get_word("t2_c", 8'h08, 1'b0, 2'b01);
    get_word("t2_d", 8'h11, 1'b1, 2'b10);
    req = 2'b00;
    tick;
    chk("t2_idle", 32'(busy), 32'd0);

    // Test 3: a seed load in the same cycle as a request goes first.
    seed_we = 1'b1; seed_in = 8'hFF; req = 2'b01;
    tick;
    chk("t3_no_gnt", 32'(gnt), 32'd0);
    chk("t3_idle", 32'(busy), 32'd0);
    seed_we = 1'b0;
    tick;
    chk("t3_gnt", 32'(gnt), 32'h1);
    tick;
    chk("t3_vld", 32'(vld), 32'd1);
    chk("t3_data", 32'(data), 32'hFE);
    req = 2'b00;
    tick;

    // Test 4: a zero seed is replaced by 01.
    seed_we = 1'b1; seed_in = 8'h00;
    tick;
    seed_we = 1'b0; req = 2'b01;
    get_word("t4", 8'h02, 1'b0, 2'b01);

    // Test 5: hold the word for 10 cycles. A seed load attempted meanwhile is dropped.
    rdy = 1'b0; req = 2'b00;
    seed_we = 1'b1; seed_in = 8'hAA;
    for (int i = 0; i < 10; i++) begin
      tick;
      seed_we = 1'b0;
      chk("t5_vld", 32'(vld), 32'd1);
      chk("t5_data", 32'(data), 32'h02);
      chk("t5_busy", 32'(busy), 32'd1);
    end
    rdy = 1'b1;
    tick;
    chk("t5_hs_vld", 32'(vld), 32'd0);
    chk("t5_hs_busy", 32'(busy), 32'd0);
    req = 2'b01;
    get_word("t5_after", 8'h04, 1'b0, 2'b01);
    req = 2'b00;
    tick;

    // Test 6: STEPS=8 instance. Assert reset in the middle of STEP.
    rst8 = 1'b0; req8 = 2'b01; rdy8 = 1'b1;
    tick;
    chk("t6_gnt", 32'(gnt8), 32'h1);
    req8 = 2'b00;
    tick; tick; tick;
    chk("t6_midbusy", 32'(busy8), 32'd1);
    rst8 = 1'b1;
    tick;
    rst8 = 1'b0;
    chk("t6_rst_gnt", 32'(gnt8), 32'd0);
    chk("t6_rst_vld", 32'(vld8), 32'd0);
    chk("t6_rst_data", 32'(data8), 32'd0);
    chk("t6_rst_id", 32'(id8), 32'd0);
    chk("t6_rst_busy", 32'(busy8), 32'd0);
    req8 = 2'b01;
    n = 0;
    do begin tick; n++; req8 = 2'b00; end while (!vld8 && n < 30);
    chk("t6_lat", 32'(n), 32'd9);
    chk("t6_data", 32'(data8), 32'h1C);
    chk("t6_id", 32'(id8), 32'd0);
    tick;
    chk("t6_done", 32'(busy8), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
